// File: rtl/seqidx_gen_pkg.sv
// rtl/seqidx_gen_pkg.sv - shared types and constants for the sequence index generator
// Contents: run/pause state enum, index width, wrap-around index step helper.
package seqidx_gen_pkg;

  localparam int IDX_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  // Modulo-32 step: natural wrap of the 5-bit index gives 31->0 and 0->31.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx,
                                                input logic             down);
    return down ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
  endfunction

endpackage

// File: rtl/seqidx_gen_btn_debounce.sv
// rtl/seqidx_gen_btn_debounce.sv - button synchronizer, debouncer and press detector
// Ports: clk, rst (sync active-high), btn_raw (async button), press (1-cycle pulse on accepted press).
module btn_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q,   deb_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // The counter tracks consecutive disagreeing cycles; any agreement restarts it,
    // so a glitch shorter than DEB_CYCLES never flips the accepted level.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/seqidx_gen.sv
// rtl/seqidx_gen.sv - free-running / single-step 5-bit sequence index generator
// Ports: clk, rst (sync active-high), speed[1:0] (period = DIV_BASE << speed), dir (1 = down),
//        btn_run / btn_step (raw buttons), seqidx[4:0], step_stb (new-index pulse), running.
module seqidx_gen
  import seqidx_gen_pkg::*;
#(
  parameter int DIV_BASE   = 1000000,
  parameter int DEB_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       speed,
  input  logic             dir,
  input  logic             btn_run,
  input  logic             btn_step,
  output logic [IDX_W-1:0] seqidx,
  output logic             step_stb,
  output logic             running
);

  // Enough bits for DIV_BASE << 3 with headroom.
  localparam int PW = $clog2(DIV_BASE) + 4;

  run_state_e       state_q, state_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             stb_q,   stb_d;

  logic             run_press;
  logic             step_press;
  logic             step_go;
  logic [PW-1:0]    term;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_run),
    .press   (run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_step),
    .press   (step_press)
  );

  assign term = (PW'(DIV_BASE) << speed) - PW'(1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    stb_d   = 1'b0;
    step_go = 1'b0;
    case (state_q)
      ST_RUN: begin
        // >= rather than == so a speed reduction mid-count steps at once
        // instead of running the counter round its full range.
        if (pre_q >= term) begin
          step_go = 1'b1;
          pre_d   = '0;
        end else begin
          pre_d = pre_q + PW'(1);
        end
        if (run_press) begin
          state_d = ST_PAUSE;
          pre_d   = '0;
        end
      end
      ST_PAUSE: begin
        pre_d = '0;
        // A run press wins over a simultaneous step press.
        if (run_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          step_go = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        pre_d   = '0;
      end
    endcase
    if (step_go) begin
      idx_d = idx_next(idx_q, dir);
      stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pre_q   <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
    end
  end

  assign seqidx   = idx_q;
  assign step_stb = stb_q;
  assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_seqidx_gen.sv
// tb/tb_seqidx_gen.sv - self-checking bench for seqidx_gen (DIV_BASE=4, DEB_CYCLES=3)
module tb_seqidx_gen;

  localparam int DB = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed = 2'd0;
  logic       dir = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic [4:0] seqidx;
  logic       step_stb;
  logic       running;

  seqidx_gen #(.DIV_BASE(DB), .DEB_CYCLES(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .speed    (speed),
    .dir      (dir),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .seqidx   (seqidx),
    .step_stb (step_stb),
    .running  (running)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   t0 = 0;
  logic prev_stb = 1'b0;

  typedef struct {
    int at;
    int val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0] speed;
    logic       dir;
    int         nsteps;
    int         period;
    int         first;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (rel cycle %0d)", name, act, req, ncyc - t0);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic run_to(input int r);
    while (ncyc - t0 < r) cyc1();
  endtask

  task automatic do_reset(input logic [1:0] sp, input logic d);
    speed    = sp;
    dir      = d;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    rst      = 1'b1;
    cyc1();
    cyc1();
    check("rst_seqidx", int'(seqidx), 0);
    check("rst_step_stb", int'(step_stb), 0);
    check("rst_running", int'(running), 1);
    rst      = 1'b0;
    t0       = ncyc;
    prev_stb = 1'b0;
  endtask

  task automatic sample();
    exp_t e;
    if (step_stb) begin
      check("stb_gap", int'(prev_stb), 0);
      if (sbq.size() == 0) begin
        check("sb_extra_step", int'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        check("sb_seqidx", int'(seqidx), e.val);
        check("sb_time", ncyc - t0, e.at);
      end
    end
    prev_stb = step_stb;
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b0, 34, 4, 1};
    vecs[1] = '{2'd0, 1'b1, 3, 4, 31};
    vecs[2] = '{2'd1, 1'b0, 3, 8, 1};
    vecs[3] = '{2'd2, 1'b1, 2, 16, 31};
    vecs[4] = '{2'd3, 1'b1, 2, 32, 31};

    // Free-running vectors through the scoreboard.
    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].speed, vecs[v].dir);
      for (int k = 1; k <= vecs[v].nsteps; k++) begin
        exp_t e;
        e.at  = k * vecs[v].period;
        e.val = (vecs[v].dir ? (vecs[v].first - (k - 1)) : (vecs[v].first + (k - 1))) & 31;
        sbq.push_back(e);
      end
      for (int c = 0; c < vecs[v].nsteps * vecs[v].period + vecs[v].period - 1; c++) begin
        cyc1();
        sample();
      end
      check("sb_drain", int'(sbq.size()), 0);
      sbq.delete();
    end

    // Speed drop 3 -> 0 with the prescaler already at 20.
    do_reset(2'd3, 1'b1);
    run_to(20);
    check("spd_pre_stb", int'(step_stb), 0);
    check("spd_pre_idx", int'(seqidx), 0);
    speed = 2'd0;
    cyc1();
    check("spd_drop_stb", int'(step_stb), 1);
    check("spd_drop_idx", int'(seqidx), 31);
    run_to(24);
    check("spd_gap_stb", int'(step_stb), 0);
    run_to(25);
    check("spd_next_stb", int'(step_stb), 1);
    check("spd_next_idx", int'(seqidx), 30);

    // Run button pauses, step button single-steps, run button resumes.
    do_reset(2'd0, 1'b0);
    run_to(5);
    btn_run = 1'b1;
    run_to(10);
    check("pause_not_yet", int'(running), 1);
    run_to(11);
    check("pause_running", int'(running), 0);
    check("pause_idx", int'(seqidx), 2);
    run_to(15);
    btn_run = 1'b0;
    run_to(30);
    check("frozen_idx", int'(seqidx), 2);
    check("frozen_running", int'(running), 0);
    btn_step = 1'b1;
    run_to(35);
    check("sstep_before", int'(step_stb), 0);
    run_to(36);
    check("sstep_stb", int'(step_stb), 1);
    check("sstep_idx", int'(seqidx), 3);
    run_to(37);
    check("sstep_after", int'(step_stb), 0);
    run_to(40);
    btn_step = 1'b0;
    run_to(50);
    check("sstep_once_idx", int'(seqidx), 3);
    btn_run = 1'b1;
    run_to(55);
    check("resume_not_yet", int'(running), 0);
    run_to(56);
    check("resume_running", int'(running), 1);
    run_to(59);
    check("resume_gap_stb", int'(step_stb), 0);
    run_to(60);
    check("resume_step_stb", int'(step_stb), 1);
    check("resume_step_idx", int'(seqidx), 4);
    btn_run = 1'b0;

    // Two-cycle glitch on the run button is rejected.
    run_to(70);
    btn_run = 1'b1;
    run_to(72);
    btn_run = 1'b0;
    run_to(90);
    check("glitch_running", int'(running), 1);
    check("glitch_idx", int'(seqidx), 11);

    // Run press lands on the same cycle as a prescaler terminal.
    btn_run = 1'b1;
    run_to(95);
    check("coinc_pre_stb", int'(step_stb), 0);
    run_to(96);
    check("coinc_stb", int'(step_stb), 1);
    check("coinc_idx", int'(seqidx), 13);
    check("coinc_running", int'(running), 0);
    run_to(100);
    btn_run = 1'b0;
    run_to(110);
    check("coinc_frozen_idx", int'(seqidx), 13);

    // Run and step pressed together while paused.
    btn_run  = 1'b1;
    btn_step = 1'b1;
    run_to(116);
    check("both_running", int'(running), 1);
    check("both_stb", int'(step_stb), 0);
    check("both_idx", int'(seqidx), 13);
    run_to(120);
    check("both_next_stb", int'(step_stb), 1);
    check("both_next_idx", int'(seqidx), 14);
    btn_run  = 1'b0;
    btn_step = 1'b0;

    // Pause at 17, then a one-cycle reset.
    run_to(126);
    btn_run = 1'b1;
    run_to(132);
    check("p17_idx", int'(seqidx), 17);
    check("p17_running", int'(running), 0);
    run_to(140);
    btn_run = 1'b0;
    run_to(145);
    check("p17_frozen_idx", int'(seqidx), 17);
    rst = 1'b1;
    cyc1();
    check("mid_rst_idx", int'(seqidx), 0);
    check("mid_rst_running", int'(running), 1);
    check("mid_rst_stb", int'(step_stb), 0);
    rst = 1'b0;
    t0  = ncyc;
    run_to(3);
    check("post_rst_gap", int'(step_stb), 0);
    run_to(4);
    check("post_rst_stb", int'(step_stb), 1);
    check("post_rst_idx", int'(seqidx), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
